// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Multi-cycle a - b - borrow_in, one nibble per clock, LSB first,
//            through a registered borrow chain under a start/done handshake.
//            Optional signed-overflow flag enabled by SERIAL_SUBTRACTOR_OVF_EN
//            (undefined: overflow tied 0, sign tracking registers removed).
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int NUM_BITS = 16
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                borrow_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] diff,
    output logic                borrow_out,
    output logic                overflow
);

    localparam int c_NIBS  = NUM_BITS / 4;
    localparam int c_CNT_W = (c_NIBS > 1) ? $clog2(c_NIBS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NIBS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [NUM_BITS-1:0] r_a;
    logic [NUM_BITS-1:0] r_b;
    logic [NUM_BITS-1:0] r_acc;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_borrow;
    logic                r_busy;
    logic                r_done;
    logic [NUM_BITS-1:0] r_diff;
    logic                r_bout;

    logic [4:0]          w_sum;
    logic [NUM_BITS-1:0] w_acc_next;
    logic                w_last;

    // Nibble step: a_n + ~b_n + ~borrow; the accumulator gets nibble k patched in
    always_comb begin
        w_sum      = {1'b0, r_a[3:0]} + {1'b0, ~r_b[3:0]} + {4'b0000, ~r_borrow};
        w_acc_next = r_acc;
        w_acc_next[{r_cnt, 2'b00} +: 4] = w_sum[3:0];
        w_last     = (r_state == S_RUN) && (r_cnt == c_LAST);
    end

    // Control FSM, operand shift registers, borrow chain and result registers
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= borrow_in;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_borrow <= ~w_sum[4];
                    r_a      <= r_a >> 4;
                    r_b      <= r_b >> 4;
                    if (w_last) begin
                        // Result registers see the final nibble on this same edge
                        r_diff  <= w_acc_next;
                        r_bout  <= ~w_sum[4];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    // Capture operand signs at accept; flag overflow together with diff
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_a_msb <= a[NUM_BITS-1];
                r_b_msb <= b[NUM_BITS-1];
            end
            if (w_last) begin
                r_ovf <= (r_a_msb != r_b_msb) && (w_acc_next[NUM_BITS-1] != r_a_msb);
            end
        end
    end

    assign overflow = r_ovf;
`else
    assign overflow = 1'b0;
`endif

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Self-checking bench for serial_subtractor (NUM_BITS = 16), with
//            expected results queued at stimulus time and popped on done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int N = 16;

    typedef struct packed {
        logic [N-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         borrow_in = 1'b0;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    serial_subtractor #(.NUM_BITS(N)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: 17-bit unsigned subtract plus signed-overflow rule
    function automatic exp_t model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic mbin);
        logic [N:0] r;
        exp_t e;
        r = {1'b0, ma} - {1'b0, mb} - {{N{1'b0}}, mbin};
        e.diff = r[N-1:0];
        e.bout = r[N];
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        e.ovf = (ma[N-1] != mb[N-1]) && (r[N-1] != ma[N-1]);
`else
        e.ovf = 1'b0;
`endif
        return e;
    endfunction

    // Present operands with start for one edge (E0) and queue the expected result
    task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ibin);
        @(negedge clk);
        a = ia; b = ib; borrow_in = ibin; start = 1'b1;
        sb.push_back(model(ia, ib, ibin));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait (bounded) for done, counting negedges since E0 and busy-high samples
    task automatic wait_done(output int lat, output int busy_cnt, output bit timeout);
        lat = 0; busy_cnt = 0; timeout = 1'b0;
        forever begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
            if (done) break;
            if (lat > 20) begin timeout = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, diff, borrow_out, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                     busy, done, diff, borrow_out, overflow);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet[%0d]: got busy=%b done=%b, want 0 0", i, busy, done);
            end
        end
    endtask

    task automatic test_vector(input string name, input logic [N-1:0] ia, input logic [N-1:0] ib,
                               input logic ibin, input bit check_timing);
        int lat, bc; bit to; exp_t e;
        issue(ia, ib, ibin);
        wait_done(lat, bc, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s_timeout: no done within 20 cycles, want done", name);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        checks++;
        if ({diff, borrow_out, overflow} !== {e.diff, e.bout, e.ovf}) begin
            errors++;
            $display("FAIL %s_result: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                     name, diff, borrow_out, overflow, e.diff, e.bout, e.ovf);
        end
        if (check_timing) begin
            checks++;
            if (lat !== 5 || bc !== 4) begin
                errors++;
                $display("FAIL %s_timing: got latency=%0d busy=%0d, want 5 and 4", name, lat, bc);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || diff !== e.diff) begin
                errors++;
                $display("FAIL %s_done_pulse: got done=%b diff=%h after pulse, want 0 %h",
                         name, done, diff, e.diff);
            end
        end
    endtask

    task automatic test_handshake_abuse;
        int lat, bc; bit to; exp_t e;
        issue(16'hA5C3, 16'h1234, 1'b0);
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; borrow_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'h0F0F; b = 16'hF0F0;
        wait_done(lat, bc, to);
        lat += 2;
        e = sb.pop_front();
        checks++;
        if (to || {diff, borrow_out, overflow} !== {e.diff, e.bout, e.ovf} || lat !== 5) begin
            errors++;
            $display("FAIL abuse_result: got diff=%h bout=%b ovf=%b lat=%0d to=%b, want diff=%h bout=%b ovf=%b lat=5",
                     diff, borrow_out, overflow, lat, to, e.diff, e.bout, e.ovf);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abuse_not_queued: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_op;
        bit seen = 1'b0;
        issue(16'h4321, 16'h1111, 1'b0);
        void'(sb.pop_front());
        @(posedge clk);          // E1
        #1 n_rst = 1'b0;
        @(posedge clk);          // E2: reset sampled
        #1 n_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        checks++;
        if (seen || {diff, borrow_out, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_mid_op: got activity=%b diff=%h bout=%b ovf=%b, want 0 and all 0",
                     seen, diff, borrow_out, overflow);
        end
        test_vector("after_reset", 16'h7000, 16'h9000, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back;
        int t1, t2, bc; bit to1, to2; exp_t e;
        @(negedge clk);
        a = 16'h3C3C; b = 16'h4D4D; borrow_in = 1'b0; start = 1'b1;
        sb.push_back(model(16'h3C3C, 16'h4D4D, 1'b0));
        sb.push_back(model(16'h3C3C, 16'h4D4D, 1'b0));
        wait_done(t1, bc, to1);
        e = sb.pop_front();
        checks++;
        if (to1 || {diff, borrow_out, overflow} !== {e.diff, e.bout, e.ovf}) begin
            errors++;
            $display("FAIL b2b_first: got diff=%h bout=%b to=%b, want diff=%h bout=%b",
                     diff, borrow_out, to1, e.diff, e.bout);
        end
        wait_done(t2, bc, to2);
        start = 1'b0;
        e = sb.pop_front();
        checks++;
        if (to2 || t2 !== 6 || {diff, borrow_out, overflow} !== {e.diff, e.bout, e.ovf}) begin
            errors++;
            $display("FAIL b2b_second: got spacing=%0d diff=%h to=%b, want spacing=6 diff=%h",
                     t2, diff, to2, e.diff);
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_vector("basic",      16'h1234, 16'h0234, 1'b0, 1'b1);
        test_vector("underflow",  16'h0000, 16'h0001, 1'b0, 1'b0);
        test_vector("borrow_in",  16'h0005, 16'h0003, 1'b1, 1'b0);
        test_vector("signed_ovf", 16'h8000, 16'h0001, 1'b0, 1'b0);
        test_vector("neg_ovf",    16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
        test_vector("equal_bin",  16'hBEEF, 16'hBEEF, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            test_vector("random", 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        end
        test_handshake_abuse();
        test_reset_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
